drum_step_sequencer: RTL and testbench

//  Master step sequencer for the drum machine. Walks a STEPS-long pattern at a programmable step period.

---
 rtl/drum_step_sequencer_if.sv | 30 +++
 rtl/drum_step_sequencer.sv | 129 ++++++++++++
 tb/tb_drum_step_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/drum_step_sequencer_if.sv
// Control/pattern inputs and trigger/status outputs of the drum step sequencer.
// The master side drives transport and pattern; the slave side is the sequencer.
interface drum_step_sequencer_if #(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned STEPS      = 16,
  parameter int unsigned PERIOD_W   = 25
);
  localparam int unsigned IdxW = $clog2(STEPS);

  logic                         play_btn;
  logic                         stop_btn;
  logic [PERIOD_W-1:0]          step_period;
  logic [NUM_TRACKS*STEPS-1:0]  pattern;
  logic [NUM_TRACKS-1:0]        mute;
  logic [NUM_TRACKS-1:0]        trig;
  logic                         step_tick;
  logic                         bar_wrap;
  logic [IdxW-1:0]              step_idx;
  logic                         playing;

  modport master (
    output play_btn, stop_btn, step_period, pattern, mute,
    input  trig, step_tick, bar_wrap, step_idx, playing
  );

  modport slave (
    input  play_btn, stop_btn, step_period, pattern, mute,
    output trig, step_tick, bar_wrap, step_idx, playing
  );
endinterface

// File: rtl/drum_step_sequencer.sv
// Master step sequencer: walks a STEPS-long pattern at a programmable period, firing one-cycle
// per-track triggers, with play/pause/stop transport, per-track mute and a bar-wrap strobe.
module drum_step_sequencer #(
  parameter int unsigned NUM_TRACKS = 4,
  parameter int unsigned STEPS      = 16,
  parameter int unsigned PERIOD_W   = 25
) (
  input logic                  clk,
  input logic                  reset,
  drum_step_sequencer_if.slave bus
);
  localparam int unsigned IdxW = $clog2(STEPS);

  typedef enum logic [1:0] {StStopped, StPlaying, StPaused} state_e;

  state_e                state_q, state_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [NUM_TRACKS-1:0] trig_q, trig_d;
  logic                  tick_q, tick_d;
  logic                  wrap_q, wrap_d;
  logic                  playing_q, playing_d;

  logic [PERIOD_W-1:0]   eff_period;
  logic                  at_end;
  logic                  fire;
  logic [STEPS-1:0]      row;
  logic [NUM_TRACKS-1:0] step_bits;

  assign eff_period = (bus.step_period < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.step_period;
  // Plain >= so a period shortened below cnt advances on the next edge instead of wrapping.
  assign at_end     = (cnt_q >= (eff_period - PERIOD_W'(1)));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StStopped;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop always wins over play
  always_comb begin
    state_d = state_q;
    if (bus.stop_btn) begin
      state_d = StStopped;
    end else begin
      unique case (state_q)
        StStopped: if (bus.play_btn) state_d = StPlaying;
        StPlaying: if (bus.play_btn) state_d = StPaused;
        StPaused:  if (bus.play_btn) state_d = StPlaying;
        default:   state_d = StStopped;
      endcase
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    fire   = 1'b0;
    wrap_d = 1'b0;
    if (bus.stop_btn) begin
      cnt_d = '0;
      idx_d = '0;
    end else begin
      unique case (state_q)
        StStopped: begin
          if (bus.play_btn) begin
            cnt_d = '0;
            idx_d = '0;
            fire  = 1'b1;
          end
        end
        StPlaying: begin
          if (!bus.play_btn) begin
            if (at_end) begin
              cnt_d  = '0;
              idx_d  = idx_q + IdxW'(1);
              fire   = 1'b1;
              wrap_d = (idx_q == IdxW'(STEPS - 1));
            end else begin
              cnt_d = cnt_q + PERIOD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
    tick_d    = fire;
    trig_d    = fire ? (step_bits & ~bus.mute) : '0;
    playing_d = (state_d == StPlaying);
  end

  // Pattern column of the step about to start
  always_comb begin
    row       = '0;
    step_bits = '0;
    for (int t = 0; t < NUM_TRACKS; t++) begin
      row          = bus.pattern[t*STEPS +: STEPS];
      step_bits[t] = row[idx_d];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      trig_q    <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      trig_q    <= trig_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      playing_q <= playing_d;
    end
  end

  assign bus.trig      = trig_q;
  assign bus.step_tick = tick_q;
  assign bus.bar_wrap  = wrap_q;
  assign bus.step_idx  = idx_q;
  assign bus.playing   = playing_q;
endmodule

// File: tb/tb_drum_step_sequencer.sv
// Randomized bench for drum_step_sequencer against an integer-level transport model.
module tb_drum_step_sequencer;
  localparam int unsigned NT = 4;
  localparam int unsigned ST = 16;
  localparam int unsigned PW = 25;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  drum_step_sequencer_if #(.NUM_TRACKS(NT), .STEPS(ST), .PERIOD_W(PW)) bus ();

  drum_step_sequencer #(.NUM_TRACKS(NT), .STEPS(ST), .PERIOD_W(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Model: mode 0=stopped 1=playing 2=paused; elapsed = clocks spent in current step so far
  int m_mode, m_elapsed, m_step;
  int exp_trig, exp_tick, exp_wrap;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_elapsed = 0; m_step = 0;
    exp_trig = 0; exp_tick = 0; exp_wrap = 0;
  endtask

  function automatic int column(input int s);
    int r = 0;
    for (int t = 0; t < NT; t++)
      if (bus.pattern[t*ST + s] && !bus.mute[t]) r |= (1 << t);
    return r;
  endfunction

  task automatic start_step(input int s);
    m_step = s; m_elapsed = 0;
    exp_tick = 1; exp_trig = column(s);
  endtask

  task automatic model_edge();
    int period;
    period = (bus.step_period < 2) ? 2 : int'(bus.step_period);
    exp_trig = 0; exp_tick = 0; exp_wrap = 0;
    if (bus.stop_btn) begin
      m_mode = 0; m_step = 0; m_elapsed = 0;
    end else if (m_mode == 0) begin
      if (bus.play_btn) begin
        m_mode = 1;
        start_step(0);
      end
    end else if (m_mode == 1) begin
      if (bus.play_btn) m_mode = 2;
      else if (m_elapsed + 1 >= period) begin
        exp_wrap = (m_step == ST - 1);
        start_step((m_step + 1) % ST);
      end else m_elapsed++;
    end else if (bus.play_btn) begin
      m_mode = 1;
    end
  endtask

  task automatic check_outputs();
    check_eq("trig", bus.trig, exp_trig);
    check_eq("step_tick", bus.step_tick, exp_tick);
    check_eq("bar_wrap", bus.bar_wrap, exp_wrap);
    check_eq("step_idx", bus.step_idx, m_step);
    check_eq("playing", bus.playing, m_mode == 1);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_play();
    bus.play_btn = 1'b1; cycle(); bus.play_btn = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop_btn = 1'b1; cycle(); bus.stop_btn = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.play_btn = 1'b0; bus.stop_btn = 1'b0;
    bus.step_period = PW'(4); bus.pattern = '0; bus.mute = '0;
    model_reset();
    cycle(); cycle();
    reset = 1'b0;
    run(3);

    // Basic bar walk: t0 on step 0, t1 on step 15
    bus.pattern = {32'h0, 16'h8000, 16'h0001};
    pulse_play();
    run(70);
    pulse_stop();

    // Pause mid-step, hold, resume
    pulse_play();
    run(5);
    pulse_play();
    run(20);
    pulse_play();
    run(10);

    // Stop and play on the same edge; stop wins
    bus.stop_btn = 1'b1; bus.play_btn = 1'b1; cycle();
    bus.stop_btn = 1'b0; bus.play_btn = 1'b0;
    run(5);
    pulse_play();
    run(6);
    pulse_stop();

    // Degenerate periods and live shortening
    bus.step_period = PW'(0);
    pulse_play();
    run(8);
    bus.step_period = PW'(1);
    run(8);
    bus.step_period = PW'(100);
    run(52);
    bus.step_period = PW'(3);
    run(10);
    pulse_stop();

    // Mute then unmute
    bus.pattern = {48'h0, 16'hFFFF};
    bus.mute = 4'b0001;
    bus.step_period = PW'(4);
    pulse_play();
    run(20);
    bus.mute = 4'b0000;
    run(10);

    // Asynchronous reset mid-bar
    run(7);
    #3 reset = 1'b1;
    #1 model_reset();
    check_outputs();
    cycle(); cycle();
    reset = 1'b0;
    run(10);
    pulse_play();
    run(10);

    // Random transport, periods, patterns and mutes
    for (int i = 0; i < 4000; i++) begin
      bus.play_btn = ($urandom_range(0, 29) == 0);
      bus.stop_btn = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 59) == 0) bus.step_period = PW'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) bus.pattern = {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) bus.mute = NT'($urandom);
      cycle();
    end
    bus.play_btn = 1'b0; bus.stop_btn = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
